// File: rtl/timer_reg_decoder.sv
// Register-access decoder for the timer peripheral: it accepts one request, then returns
// a registered write strobe, read data or unmapped-address error one cycle later.
module timer_reg_decoder #(
    parameter int ADDR_W   = 2,
    parameter int NUM_REGS = 3,
    parameter int DATA_W   = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_req,
    input  logic                       i_we,
    input  logic [ADDR_W-1:0]          i_addr,
    input  logic [DATA_W-1:0]          i_wdata,
    input  logic [NUM_REGS*DATA_W-1:0] i_rd_bus,
    input  logic                       i_err_clr,
    output logic                       o_ready,
    output logic [NUM_REGS-1:0]        o_wr_strobe,
    output logic [DATA_W-1:0]          o_wdata,
    output logic [DATA_W-1:0]          o_rdata,
    output logic                       o_rvalid,
    output logic                       o_err,
    output logic                       o_err_sticky
);

    typedef enum logic {IDLE, RESP} state_t;

    // One extra bit keeps the unsigned compare exact even when NUM_REGS == 2**ADDR_W.
    localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

    state_t                state;
    state_t                state_next;
    logic                  accept;
    logic                  we_p0;
    logic [ADDR_W-1:0]     addr_p0;
    logic [DATA_W-1:0]     wdata_p0;
    logic                  mapped_p0;
    logic [NUM_REGS-1:0]   strobe_p0;
    logic [DATA_W-1:0]     rsel_p0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (i_req) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        o_ready = (state == IDLE);
    end

    assign accept = (state == IDLE) && i_req;

    // Stage p0: captured request; only consumed in RESP, so it needs no reset.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            we_p0    <= i_we;
            addr_p0  <= i_addr;
            wdata_p0 <= i_wdata;
        end
    end

    always_comb begin
        mapped_p0 = ({1'b0, addr_p0} < NUM_REGS_W);
        strobe_p0 = '0;
        rsel_p0   = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (addr_p0 == ADDR_W'(k)) begin
                strobe_p0[k] = 1'b1;
                rsel_p0      = i_rd_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    // Stage p1: registered response, launched at the end of the RESP cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_wr_strobe <= '0;
            o_wdata     <= '0;
            o_rdata     <= '0;
            o_rvalid    <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_wr_strobe <= '0;
            o_rvalid    <= 1'b0;
            o_err       <= 1'b0;
            if (state == RESP) begin
                if (!mapped_p0) begin
                    o_err <= 1'b1;
                end else if (we_p0) begin
                    o_wr_strobe <= strobe_p0;
                    o_wdata     <= wdata_p0;
                end else begin
                    o_rvalid <= 1'b1;
                    o_rdata  <= rsel_p0;
                end
            end
        end
    end

    // A new error takes priority over a simultaneous clear.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_err_sticky <= 1'b0;
        end else if (state == RESP && !mapped_p0) begin
            o_err_sticky <= 1'b1;
        end else if (i_err_clr) begin
            o_err_sticky <= 1'b0;
        end
    end

endmodule
